hppb_mig_scheduler: RTL

- Sequences hot-page migration batches produced by the address handler: captures one batch of MIG_GRP_SIZE src/dst page pairs and dispatches them round-robin to NUM_ENG page-copy engines.
- Tracks engine completion and publishes the migration-done count that the address handler uses to pull the next batch.
- Sits between the address handler and the page-copy engines, in the axi4_mm_clk domain.

---
 rtl/hppb_sched_pkg.sv | 26 ++
 rtl/hppb_rr_pick.sv | 23 ++
 rtl/hppb_mig_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hppb_sched_pkg.sv
// Shared types and constants for the hot-page migration scheduler.
package hppb_sched_pkg;

    localparam int unsigned MIG_GRP_SIZE_DEF = 16;
    localparam int unsigned NUM_ENG_DEF      = 4;
    localparam int unsigned PAIR_IDX_W       = $clog2(MIG_GRP_SIZE_DEF);
    localparam int unsigned ENG_IDX_W        = $clog2(NUM_ENG_DEF);
    localparam int unsigned PAGE_SHIFT       = 12;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        logic [63:0] src;
        logic [63:0] dst;
    } mig_pair_t;

    // A pair whose source page number is zero carries no migration.
    function automatic logic is_null_pair(input mig_pair_t p);
        return p.src[63:PAGE_SHIFT] == '0;
    endfunction

endpackage

// File: rtl/hppb_rr_pick.sv
// Combinational round-robin picker: first free engine at or above rr_ptr, wrapping.
module hppb_rr_pick #(
    parameter int unsigned NUM_ENG = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_ENG)
) (
    input  logic [NUM_ENG-1:0] free,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_free
);

    always_comb begin
        grant    = '0;
        any_free = 1'b0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (!any_free && free[rr_ptr + IDX_W'(i)]) begin
                grant    = rr_ptr + IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hppb_mig_scheduler.sv
// Captures one batch of migration pairs and dispatches them round-robin to
// page-copy engines, counting completed batches for the address handler.
module hppb_mig_scheduler
    import hppb_sched_pkg::*;
#(
    parameter int unsigned MIG_GRP_SIZE = MIG_GRP_SIZE_DEF,
    parameter int unsigned NUM_ENG      = NUM_ENG_DEF
) (
    input  logic                axi4_mm_clk,
    input  logic                axi4_mm_rst,
    input  logic                csr_enable,
    input  logic                batch_valid,
    output logic                batch_ready,
    input  logic [63:0]         src_addr  [MIG_GRP_SIZE/2],
    input  logic [63:0]         dst_addr  [MIG_GRP_SIZE/2],
    input  logic [63:0]         src_addr1 [MIG_GRP_SIZE/2],
    input  logic [63:0]         dst_addr1 [MIG_GRP_SIZE/2],
    output logic [NUM_ENG-1:0]  eng_req_valid,
    output logic [63:0]         eng_req_src,
    output logic [63:0]         eng_req_dst,
    input  logic [NUM_ENG-1:0]  eng_req_ready,
    input  logic [NUM_ENG-1:0]  eng_done,
    output logic [63:0]         mig_done_cnt,
    output logic                batch_done,
    output logic [63:0]         csr_pair_cnt,
    output logic [63:0]         csr_skip_cnt,
    output logic [31:0]         csr_drop_cnt
);

    localparam int unsigned PW   = $clog2(MIG_GRP_SIZE);
    localparam int unsigned EW   = $clog2(NUM_ENG);
    localparam int unsigned HALF = MIG_GRP_SIZE / 2;

    sched_state_t        state, state_next;
    mig_pair_t           pair_buf [MIG_GRP_SIZE];
    mig_pair_t           cur_pair;
    logic [PW-1:0]       pair_ptr;
    logic [EW-1:0]       rr_ptr, grant, req_eng, sel_eng;
    logic [NUM_ENG-1:0]  busy, busy_live, accept_vec;
    logic                any_free, req_active, cur_null;
    logic                req_valid, accept, skip, take_batch, drain_done;

    assign batch_ready = (state == IDLE) && csr_enable;
    assign take_batch  = batch_valid && batch_ready;
    assign cur_pair    = pair_buf[pair_ptr];
    assign cur_null    = is_null_pair(cur_pair);
    assign busy_live   = busy & ~eng_done;
    // A request already on the bus keeps its engine until accepted.
    assign sel_eng     = req_active ? req_eng : grant;
    assign accept_vec  = accept ? (NUM_ENG'(1) << sel_eng) : '0;

    hppb_rr_pick #(
        .NUM_ENG (NUM_ENG),
        .IDX_W   (EW)
    ) u_rr_pick (
        .free     (~busy),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .any_free (any_free)
    );

    always_comb begin
        state_next    = state;
        eng_req_valid = '0;
        eng_req_src   = '0;
        eng_req_dst   = '0;
        req_valid     = 1'b0;
        accept        = 1'b0;
        skip          = 1'b0;
        drain_done    = 1'b0;
        case (state)
            IDLE: begin
                if (take_batch) state_next = DISPATCH;
            end
            DISPATCH: begin
                if (cur_null) begin
                    skip = 1'b1;
                end else if (req_active || any_free) begin
                    req_valid              = 1'b1;
                    eng_req_valid[sel_eng] = 1'b1;
                    eng_req_src            = cur_pair.src;
                    eng_req_dst            = cur_pair.dst;
                    accept                 = eng_req_ready[sel_eng];
                end
                if ((accept || skip) && pair_ptr == PW'(MIG_GRP_SIZE - 1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (busy_live == '0) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            state        <= IDLE;
            pair_ptr     <= '0;
            rr_ptr       <= '0;
            busy         <= '0;
            req_active   <= 1'b0;
            req_eng      <= '0;
            batch_done   <= 1'b0;
            mig_done_cnt <= '0;
            csr_pair_cnt <= '0;
            csr_skip_cnt <= '0;
            csr_drop_cnt <= '0;
        end else begin
            state      <= state_next;
            busy       <= busy_live | accept_vec;
            batch_done <= drain_done;
            if (take_batch)
                pair_ptr <= '0;
            else if (accept || skip)
                pair_ptr <= pair_ptr + 1'b1;
            if (accept) begin
                rr_ptr       <= sel_eng + 1'b1;
                req_active   <= 1'b0;
                csr_pair_cnt <= csr_pair_cnt + 64'd1;
            end else if (req_valid) begin
                req_active <= 1'b1;
                req_eng    <= sel_eng;
            end
            if (skip)
                csr_skip_cnt <= csr_skip_cnt + 64'd1;
            if (drain_done)
                mig_done_cnt <= mig_done_cnt + 64'd1;
            if (batch_valid && !batch_ready && csr_drop_cnt != '1)
                csr_drop_cnt <= csr_drop_cnt + 32'd1;
        end
    end

    // Lane 0 carries even pair indices, lane 1 odd.
    always_ff @(posedge axi4_mm_clk) begin
        if (take_batch) begin
            for (int unsigned i = 0; i < HALF; i++) begin
                pair_buf[2*i]   <= '{src: src_addr[i],  dst: dst_addr[i]};
                pair_buf[2*i+1] <= '{src: src_addr1[i], dst: dst_addr1[i]};
            end
        end
    end

endmodule
